// File: rtl/gpio_port_pkg.sv
// Shared constants and types for the GPIO port controller.
// Register addresses, address width and the request bundle layout.
package gpio_port_pkg;

    localparam int ADDR_W = 3;
    localparam int GPIO_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EVENT    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [GPIO_W-1:0] wdata;
    } gpio_req_t;

endpackage

// File: rtl/gpio_port_debounce.sv
// One GPIO input bit: synchronizer chain, debounce counter and accepted state.
// o_change pulses on the same edge at which o_stable takes its new value.
module gpio_port_debounce
    import gpio_port_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_stable,
    output logic o_change
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_diff   = (w_sync != r_stable);
    // Accept on the cycle the difference has been seen DEBOUNCE_CYCLES times in a row.
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_stable <= w_sync;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_change = w_accept;

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port: debounced inputs with sticky edge events and irq, register-driven outputs.
// Optional IRQ_MASK register at address 4 when GPIO_PORT_CTRL_IRQ_MASK_EN is defined.
module gpio_port_ctrl
    import gpio_port_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_event;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_change;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_irq_mask;
    logic [WIDTH-1:0] w_rdata;
    logic             w_accept;
    logic             w_wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_port_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .i_pin    (gpio_in[i]),
            .o_stable (w_stable[i]),
            .o_change (w_change[i])
        );
    end

    // valid/ready: a request transfers on the edge where req_valid && req_ready;
    // the response is held with rsp_valid until rsp_ready, and a new request may
    // be taken on the same edge the previous response is consumed.
    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_wr      = w_accept && req_we;
    assign w_clr     = (w_wr && req_addr == ADDR_EVENT) ? req_wdata : '0;

`ifdef GPIO_PORT_CTRL_IRQ_MASK_EN
    logic [WIDTH-1:0] r_irq_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_mask <= '0;
        end else if (w_wr && req_addr == ADDR_IRQ_MASK) begin
            r_irq_mask <= req_wdata;
        end
    end

    assign w_irq_mask = r_irq_mask;
`else
    assign w_irq_mask = '1;
`endif

    always_comb begin
        w_rdata = '0;
        case (req_addr)
            ADDR_DATA_OUT: w_rdata = r_data_out;
            ADDR_DIR:      w_rdata = r_dir;
            ADDR_DATA_IN:  w_rdata = w_stable;
            ADDR_EVENT:    w_rdata = r_event;
`ifdef GPIO_PORT_CTRL_IRQ_MASK_EN
            ADDR_IRQ_MASK: w_rdata = r_irq_mask;
`endif
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_dir       <= '0;
            r_event     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr && req_addr == ADDR_DATA_OUT) r_data_out <= req_wdata;
            if (w_wr && req_addr == ADDR_DIR)      r_dir      <= req_wdata;
            // A new edge wins over a same-cycle W1C clear of that bit.
            r_event <= (r_event & ~w_clr) | w_change;
            r_irq   <= |(r_event & w_irq_mask);
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= req_we ? '0 : w_rdata;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign gpio_out  = r_data_out;
    assign gpio_oe   = r_dir;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign irq       = r_irq;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed self-checking bench for gpio_port_ctrl (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_gpio_port_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    gpio_port_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            step(1);
            n++;
        end
        check_val("req_ready", req_ready, 1);
        step(1);
        req_valid = 1'b0;
        req_we    = 1'b0;
        check_val("rsp_valid", rsp_valid, 1);
        rdata = rsp_rdata;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        bus_xfer(1'b1, addr, data, rd);
        check_val("wr_rdata_zero", rd, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        bus_xfer(1'b0, addr, 8'h00, rd);
        check_val(tag, rd, exp);
    endtask

    initial begin
        rst       = 1'b1;
        gpio_in   = '0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        step(2);
        rst = 1'b0;

        // Reset defaults
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_gpio_out", gpio_out, 0);
        check_val("rst_gpio_oe", gpio_oe, 0);
        for (int a = 0; a < 8; a++) begin
            rd_chk($sformatf("rst_read_%0d", a), 3'(a), 8'h00);
        end
        check_val("rst_irq", irq, 0);

        // Write/read and response hold
        wr(3'd0, 8'hA5);
        check_val("gpio_out_a5", gpio_out, 8'hA5);
        wr(3'd1, 8'h0F);
        check_val("gpio_oe_0f", gpio_oe, 8'h0F);
        rd_chk("rd_data_out", 3'd0, 8'hA5);
        rd_chk("rd_dir", 3'd1, 8'h0F);
        step(1);
        rsp_ready = 1'b0;
        rd_chk("rd_hold", 3'd0, 8'hA5);
        step(3);
        check_val("hold_rsp_valid", rsp_valid, 1);
        check_val("hold_req_ready", req_ready, 0);
        check_val("hold_rdata", rsp_rdata, 8'hA5);
        rsp_ready = 1'b1;
        step(1);
        check_val("release_rsp_valid", rsp_valid, 0);

        // Glitch of 3 cycles is rejected
        gpio_in[3] = 1'b1;
        step(3);
        gpio_in[3] = 1'b0;
        step(10);
        rd_chk("glitch_data_in", 3'd2, 8'h00);
        rd_chk("glitch_event", 3'd3, 8'h00);
        check_val("glitch_irq", irq, 0);

        // 4-cycle pulse accepted at edge 6, irq at edge 7
        step(1);
        gpio_in[3] = 1'b1;
        step(3);
        step(1);
        gpio_in[3] = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 3'd2;
        step(1);
        check_val("din_edge5", rsp_rdata, 8'h00);
        req_valid = 1'b0;
        step(1);
        check_val("irq_edge6", irq, 0);
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check_val("din_edge7", rsp_rdata, 8'h08);
        check_val("irq_edge7", irq, 1);
        rd_chk("event_08", 3'd3, 8'h08);

        // Falling edge settles; clear with no race
        step(12);
        rd_chk("din_fall", 3'd2, 8'h00);
        wr(3'd3, 8'hFF);
        step(1);
        check_val("clr_irq", irq, 0);
        rd_chk("clr_event", 3'd3, 8'h00);

        // W1C clear on the same edge as a new edge on bit 3
        gpio_in[3] = 1'b1;
        step(5);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd3;
        req_wdata = 8'h08;
        step(1);
        req_valid = 1'b0;
        req_we    = 1'b0;
        check_val("race_rsp_valid", rsp_valid, 1);
        rd_chk("race_event", 3'd3, 8'h08);
        check_val("race_irq", irq, 1);

        // Mid-transaction reset
        gpio_in = '0;
        step(12);
        wr(3'd0, 8'h5A);
        step(1);
        rsp_ready = 1'b0;
        rd_chk("pre_rst_read", 3'd0, 8'h5A);
        step(2);
        check_val("pre_rst_hold", rsp_valid, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_val("mid_rst_rsp_valid", rsp_valid, 0);
        check_val("mid_rst_gpio_out", gpio_out, 0);
        check_val("mid_rst_irq", irq, 0);
        check_val("mid_rst_req_ready", req_ready, 1);
        rsp_ready = 1'b1;
        wr(3'd0, 8'h3C);
        rd_chk("post_rst_rd", 3'd0, 8'h3C);
        rd_chk("post_rst_event", 3'd3, 8'h00);

`ifdef GPIO_PORT_CTRL_IRQ_MASK_EN
        wr(3'd4, 8'h01);
        rd_chk("mask_rd", 3'd4, 8'h01);
        gpio_in[2] = 1'b1;
        step(10);
        rd_chk("masked_event", 3'd3, 8'h04);
        check_val("masked_irq", irq, 0);
        gpio_in[0] = 1'b1;
        step(10);
        check_val("unmasked_irq", irq, 1);
        rd_chk("both_event", 3'd3, 8'h05);
`else
        wr(3'd4, 8'hFF);
        rd_chk("addr4_reserved", 3'd4, 8'h00);
        wr(3'd6, 8'hFF);
        rd_chk("addr6_reserved", 3'd6, 8'h00);
        rd_chk("reserved_no_side", 3'd0, 8'h3C);
        gpio_in[2] = 1'b1;
        step(10);
        rd_chk("event_bit2", 3'd3, 8'h04);
        check_val("irq_bit2", irq, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
